// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and sizes for the byte-serial ShiftRows stage
package aes_pkg;

    typedef logic [7:0] byte_t;
    typedef logic [1:0] row_idx_t;

    localparam int ROW_BYTES = 4;
    localparam int N_ROWS    = 4;
    localparam int N_BANKS   = 2;

    // Column to read for output position idx of a row tagged with its row index.
    function automatic row_idx_t shift_col(row_idx_t idx, row_idx_t tag, bit inverse);
        return inverse ? row_idx_t'(idx - tag) : row_idx_t'(idx + tag);
    endfunction

endpackage

// File: rtl/aes_dual_row_mem.sv
// rtl/aes_dual_row_mem.sv - two-bank row buffer, synchronous write, asynchronous read
module aes_dual_row_mem
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [2:0] waddr,
    input  byte_t      wdata,
    input  logic [2:0] raddr,
    output byte_t      rdata
);

    // addr[2] selects the bank, addr[1:0] the column within the row.
    byte_t mem [N_BANKS*ROW_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/aes_row_shift_reader.sv
// rtl/aes_row_shift_reader.sv - ping-pong row buffer that emits each row rotated by its index
module aes_row_shift_reader
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr,
    input  logic     in_valid,
    output logic     in_ready,
    input  byte_t    in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output byte_t    out_data,
    output row_idx_t out_row,
    output logic     out_last
);

    localparam row_idx_t LAST_IDX = row_idx_t'(ROW_BYTES - 1);
    localparam row_idx_t LAST_ROW = row_idx_t'(N_ROWS - 1);

    logic                wr_bank;
    logic                rd_bank;
    row_idx_t            wr_idx;
    row_idx_t            rd_idx;
    row_idx_t            wr_row;
    logic     [1:0]      full;
    logic     [1:0]      full_nxt;
    row_idx_t [1:0]      tag;

    logic     wr_fire;
    logic     rd_fire;
    logic     wr_done;
    logic     rd_done;
    row_idx_t rd_col;

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign out_row   = tag[rd_bank];
    assign out_last  = out_valid && (out_row == LAST_ROW) && (rd_idx == LAST_IDX);

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    assign wr_done = wr_fire && (wr_idx == LAST_IDX);
    assign rd_done = rd_fire && (rd_idx == LAST_IDX);

    assign rd_col = shift_col(rd_idx, tag[rd_bank], INVERSE);

    // A finishing write and a finishing read always target different banks,
    // so applying both updates in order is safe.
    always_comb begin
        full_nxt = full;
        if (wr_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_row  <= '0;
            full    <= '0;
            tag     <= '0;
        end else if (clr) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_row  <= '0;
            full    <= '0;
            tag     <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_idx <= wr_idx + 2'd1;
            end
            if (wr_done) begin
                tag[wr_bank] <= wr_row;
                wr_bank      <= ~wr_bank;
                wr_row       <= wr_row + 2'd1;
            end
            if (rd_fire) begin
                rd_idx <= rd_idx + 2'd1;
            end
            if (rd_done) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    aes_dual_row_mem u_mem (
        .clk   (clk),
        .we    (wr_fire && !clr),
        .waddr ({wr_bank, wr_idx}),
        .wdata (in_data),
        .raddr ({rd_bank, rd_col}),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_aes_row_shift_reader.sv
// tb/tb_aes_row_shift_reader.sv - randomized and directed bench against a row-queue model
module tb_aes_row_shift_reader;
    import aes_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     clr = 1'b0;
    logic     in_valid = 1'b0;
    logic     out_ready = 1'b0;
    byte_t    in_data = '0;
    logic     in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
    byte_t    out_data0, out_data1;
    row_idx_t out_row0, out_row1;

    always #5 clk = ~clk;

    aes_row_shift_reader #(.INVERSE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_row(out_row0), .out_last(out_last0)
    );

    aes_row_shift_reader #(.INVERSE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_row(out_row1), .out_last(out_last1)
    );

    typedef struct {
        byte_t d0;
        byte_t d1;
        int    row;
        bit    last;
    } exp_t;

    exp_t  exp_q[$];
    byte_t part[$];
    int    rows_done = 0;
    int    total = 0;
    int    bad = 0;
    int    n_acc = 0;
    bit    cap_en = 1'b0;
    byte_t cap0[$];
    byte_t cap1[$];
    logic  s_ir, s_ov;
    byte_t s_d0;

    byte_t want0[16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07, 8'h04,
                         8'h0A, 8'h0B, 8'h08, 8'h09, 8'h0F, 8'h0C, 8'h0D, 8'h0E};
    byte_t want1[16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h04, 8'h05, 8'h06,
                         8'h0A, 8'h0B, 8'h08, 8'h09, 8'h0D, 8'h0E, 8'h0F, 8'h0C};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        part.delete();
        rows_done = 0;
    endtask

    // A completed row becomes a group of four output bytes: rotate left by r
    // for the forward transform and right by r for the inverse one.
    task automatic model_push(input byte_t d);
        exp_t e;
        int   r;
        part.push_back(d);
        if (part.size() == 4) begin
            r = rows_done % 4;
            for (int i = 0; i < 4; i++) begin
                e.d0   = part[(i + r) % 4];
                e.d1   = part[(i - r + 4) % 4];
                e.row  = r;
                e.last = (r == 3) && (i == 3);
                exp_q.push_back(e);
            end
            part.delete();
            rows_done++;
        end
    endtask

    task automatic step(input logic v, input byte_t d, input logic r, input logic c);
        int   held;
        logic exp_ir, exp_ov, acc, rd;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clr       = c;
        @(negedge clk);
        held   = (exp_q.size() + 3) / 4;
        exp_ir = (held < 2);
        exp_ov = (exp_q.size() > 0);
        s_ir = in_ready0;
        s_ov = out_valid0;
        s_d0 = out_data0;
        check("in_ready0", in_ready0, exp_ir);
        check("in_ready1", in_ready1, exp_ir);
        check("out_valid0", out_valid0, exp_ov);
        check("out_valid1", out_valid1, exp_ov);
        check("out_last0", out_last0, exp_ov ? exp_q[0].last : 1'b0);
        check("out_last1", out_last1, exp_ov ? exp_q[0].last : 1'b0);
        if (exp_ov) begin
            check("out_data0", out_data0, exp_q[0].d0);
            check("out_data1", out_data1, exp_q[0].d1);
            check("out_row0", out_row0, exp_q[0].row);
            check("out_row1", out_row1, exp_q[0].row);
        end
        acc = v && exp_ir;
        rd  = exp_ov && r;
        if (rd && cap_en) begin
            cap0.push_back(out_data0);
            cap1.push_back(out_data1);
        end
        if (c) begin
            model_clear();
        end else begin
            if (rd) void'(exp_q.pop_front());
            if (acc) begin
                model_push(d);
                n_acc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_known_state(input string tag);
        cap0.delete();
        cap1.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, byte_t'(i), 1'b1, 1'b0);
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);
        cap_en = 1'b0;
        check({tag, "_count"}, cap0.size(), 16);
        if (cap0.size() == 16 && cap1.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check({tag, "_fwd"}, cap0[i], want0[i]);
                check({tag, "_inv"}, cap1[i], want1[i]);
            end
        end
    endtask

    initial begin
        int base;
        int first;
        int ov_cnt;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready0, 1'b1);
        check("rst_out_valid", out_valid0, 1'b0);
        check("rst_out_row", out_row0, 2'd0);
        check("rst_out_last", out_last0, 1'b0);
        rst_n = 1'b1;

        run_known_state("seq_a");

        base = n_acc;
        for (int i = 0; i < 12; i++) step(1'b1, byte_t'(i), 1'b0, 1'b0);
        check("bp_accepted", n_acc - base, 8);
        check("bp_in_ready", s_ir, 1'b0);
        check("bp_out_valid", s_ov, 1'b1);
        check("bp_out_data", s_d0, 8'h00);
        first = -1;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            if (s_ir && first < 0) first = k;
        end
        check("bp_ready_return", first, 4);
        repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);

        ov_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, byte_t'($urandom), 1'b1, 1'b0);
            if (i >= 4 && s_ov) ov_cnt++;
        end
        check("b2b_no_bubble", ov_cnt, 28);
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) step(1'b1, byte_t'(i), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid0, 1'b0);
        check("midrst_in_ready", in_ready0, 1'b1);
        check("midrst_out_valid1", out_valid1, 1'b0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_known_state("seq_b");

        for (int i = 0; i < 4; i++) step(1'b1, byte_t'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("clr_out_valid", s_ov, 1'b0);
        check("clr_in_ready", s_ir, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(3, 0) != 0, byte_t'($urandom),
                 $urandom_range(2, 0) != 0, $urandom_range(96, 0) == 0);
        end
        repeat (12) step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
